// File: rtl/div_seq_ctrl.sv
// Radix-2 restoring divide sequencer (LA32 DIV/MOD .W/.WU), WIDTH+1 cycles accept->out_valid, result held until out_ready.
// Define DIV_SEQ_FAST_EN to finish divide-by-zero, signed overflow and |src1|<|src2| in 2 cycles; flush aborts from any state.
module div_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       div_op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   rem_q, quo_q, dvs_q, result_q;
  logic               dvz_q, qneg_q, rneg_q, rem_sel_q;
  logic               in_ready_q, out_valid_q, busy_q;
`ifdef DIV_SEQ_FAST_EN
  logic               fast_q;
  logic               ovf_d, fast_hit_d;
`endif

  logic               sgn_d, a_neg_d, b_neg_d;
  logic [WIDTH-1:0]   abs_a_d, abs_b_d;
  logic [WIDTH:0]     sh_d;
  logic [WIDTH+1:0]   diff_d;
  logic [WIDTH-1:0]   step_rem_d, step_quo_d, fix_quo_d, fix_rem_d;

  always_comb begin
    sgn_d   = ~div_op[1];
    a_neg_d = sgn_d & src1[WIDTH-1];
    b_neg_d = sgn_d & src2[WIDTH-1];
    abs_a_d = a_neg_d ? -src1 : src1;
    abs_b_d = b_neg_d ? -src2 : src2;
`ifdef DIV_SEQ_FAST_EN
    ovf_d      = sgn_d && (src1 == {1'b1, {(WIDTH-1){1'b0}}}) && (src2 == '1);
    fast_hit_d = (src2 == '0) || ovf_d || (abs_a_d < abs_b_d);
`endif
    // One extra bit of headroom so |0x80000000| subtracts as an unsigned value.
    sh_d       = {rem_q, quo_q[WIDTH-1]};
    diff_d     = {1'b0, sh_d} - {2'b00, dvs_q};
    step_rem_d = diff_d[WIDTH+1] ? sh_d[WIDTH-1:0] : diff_d[WIDTH-1:0];
    step_quo_d = {quo_q[WIDTH-2:0], ~diff_d[WIDTH+1]};
    fix_quo_d  = dvz_q ? '1 : (qneg_q ? -quo_q : quo_q);
    fix_rem_d  = rneg_q ? -rem_q : rem_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      result_q    <= '0;
      dvz_q       <= 1'b0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      rem_sel_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef DIV_SEQ_FAST_EN
      fast_q      <= 1'b0;
`endif
    end else if (flush) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          state_q    <= BUSY;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b1;
          cnt_q      <= '0;
          rem_q      <= '0;
          quo_q      <= abs_a_d;
          dvs_q      <= abs_b_d;
          dvz_q      <= (src2 == '0);
          qneg_q     <= a_neg_d ^ b_neg_d;
          rneg_q     <= a_neg_d;
          rem_sel_q  <= div_op[0];
`ifdef DIV_SEQ_FAST_EN
          fast_q     <= fast_hit_d;
          // Trivial cases are preloaded as final magnitudes; FIX applies the signs.
          if (fast_hit_d) begin
            rem_q <= ovf_d ? '0 : abs_a_d;
            quo_q <= ovf_d ? {1'b1, {(WIDTH-1){1'b0}}} : '0;
          end
`endif
        end
        BUSY:
`ifdef DIV_SEQ_FAST_EN
          if (fast_q) state_q <= FIX;
          else
`endif
          begin
            rem_q <= step_rem_d;
            quo_q <= step_quo_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH-1)) state_q <= FIX;
          end
        FIX: begin
          result_q    <= rem_sel_q ? fix_rem_d : fix_quo_d;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: if (out_ready) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign busy      = busy_q;
endmodule
